operand2_encoder: RTL and testbench
===================================

OPERAND2_ENCODER -- requirements
Module: operand2_encoder

Interface
REQ-001 The block SHALL expose `clk`, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose `rst`, input, 1, reset, asynchronous, active-low.
REQ-003 The block SHALL expose `start`, input, 1, request strobe, sampled only while `busy`=0.
REQ-004 The block SHALL expose `value`, input, 32, the constant to encode, captured on an accepted `start`.
REQ-005 The block SHALL expose `ld_str`, input, 1, mode select captured on an accepted `start`: 1 = memory-offset mode, 0 = data-processing immediate mode.
REQ-006 The block SHALL expose `busy`, output, 1, high from the cycle after an accepted `start` until `done` is asserted.
REQ-007 The block SHALL expose `done`, output, 1, a single-cycle completion pulse.
REQ-008 The block SHALL expose `valid`, output, 1, high when the captured value is encodable; meaningful from `done` onward.
REQ-009 The block SHALL expose `shift_operand`, output, 12, the encoding that the operand-2 generator expands back to the captured value.

Function
REQ-010 States SHALL be IDLE, SEARCH and DONE; IDLE->SEARCH on `start` high at a clock edge while in IDLE; DONE->IDLE unconditionally after one cycle.
REQ-011 On accepting `start`, the block SHALL latch `value` and `ld_str` internally, clear rotation counter r to 0, and ignore later changes on `value` and `ld_str`.
REQ-012 In immediate mode, each SEARCH cycle SHALL form cand = ROL(latched value, 2*r) and declare a match when cand[31:7] is all zeros or all ones.
REQ-013 The match condition SHALL mean ROR(sign-extend-8(cand[7:0]), 2*r) equals the latched value.
REQ-014 On a match, the result SHALL be `shift_operand` = {r[3:0], cand[7:0]} and `valid`=1; the lowest matching r SHALL win.
REQ-015 The counter r SHALL range 0..15; a search that finds no match through r=15 SHALL give `valid`=0 and `shift_operand`=12'h000.
REQ-016 In memory-offset mode, SEARCH SHALL evaluate once: if value[31:11] is uniform, the result SHALL be `valid`=1 and `shift_operand`=value[11:0]; otherwise `valid`=0 and `shift_operand`=0; the block then goes to DONE.
REQ-017 `done` SHALL be high exactly in the DONE cycle. Taking the start-sampling edge as cycle 0, a result settled at evaluation k (0-based) SHALL assert `done` in cycle k+2.
REQ-018 `valid` and `shift_operand` SHALL be registered, update at the edge entering DONE, and hold until the next accepted `start`; that `start` SHALL clear both.
REQ-019 `start` while `busy`=1 or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 `busy` SHALL be high exactly while in SEARCH.

Reset
REQ-021 `rst` low SHALL force IDLE, r=0, `busy`=0, `done`=0, `valid`=0 and `shift_operand`=0 immediately, including mid-SEARCH; the aborted request is discarded.
REQ-022 After `rst` is released, the first `start` SHALL be acceptable at the first clock edge.

Configuration
REQ-023 With macro `OPERAND2_EARLY_EXIT_EN` defined, immediate-mode SEARCH SHALL go to DONE at the first match, giving `done` in cycle r+2.
REQ-024 Without `OPERAND2_EARLY_EXIT_EN`, immediate-mode SEARCH SHALL always scan r=0..15, giving `done` in cycle 17.
REQ-025 The result SHALL be identical in both builds: lowest matching r; memory-offset mode unaffected.

Verification
REQ-026 value=0x0000007F, ld_str=0 -> valid=1, shift_operand=0x07F, done cycle 2 (early-exit) / 17 (without).
REQ-027 value=0x3F000000, ld_str=0 -> valid=1, shift_operand=0x43F, done cycle 6 (early-exit) / 17 (without); also value=0xFFFFFF80 -> 0x080.
REQ-028 value=0x000000FF, ld_str=0 -> valid=0, shift_operand=0x000, done cycle 17 in both builds.
REQ-029 ld_str=1: value=0xFFFFF800 -> valid=1, shift_operand=0x800, done cycle 2; value=0x00000800 -> valid=0.
REQ-030 Second `start` with value=0x1 in cycle 3 of the 0x3F000000 search -> ignored, result 0x43F; `rst` low in cycle 3 of that search -> all outputs 0 at once, state IDLE, no `done` pulse.

Source files
------------

// File: rtl/operand2_encoder.sv
// Operand-2 constant encoder.
// Searches for a 12-bit operand-2 encoding of a 32-bit constant. There are two modes.
//   Immediate mode (ld_str=0): the field is {rot[3:0], imm8}. It expands to
//     ROR(sign-extend-8(imm8), 2*rot). The lowest rot that works is chosen.
//   Memory-offset mode (ld_str=1): the value must already be a sign-extended 12-bit offset.
// Optional build macro: OPERAND2_EARLY_EXIT_EN.
//   When defined, an immediate-mode search stops at the first match.
//   When undefined, it always scans rot 0..15.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         request strobe, sampled only in IDLE
//   value         constant to encode, captured on an accepted start
//   ld_str        mode select, captured on an accepted start
//   busy          high while searching
//   done          single-cycle completion pulse
//   valid         captured value is encodable (meaningful from done onward)
//   shift_operand 12-bit encoding (zero when not encodable)
module operand2_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        ld_str,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [11:0] shift_operand
);

  localparam int unsigned VW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned SW = 12;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state, state_d;
  logic [RW-1:0] r, r_d;
  logic [VW-1:0] val_q, val_d;
  logic          mode_q, mode_d;
  logic          found_q, found_d;
  logic [SW-1:0] best_q, best_d;
  logic          valid_d;
  logic [SW-1:0] so_d;

  logic [2*VW-1:0] dbl;
  logic [VW-1:0]   cand;
  logic            imm_match;
  logic            mem_match;
  logic            last_eval;

  // Rotate-left by 2*r via a doubled word, which avoids the 32-bit shift at r=0.
  always_comb begin
    dbl  = {val_q, val_q} << {r, 1'b0};
    cand = dbl[2*VW-1:VW];
  end

  // A value is encodable when the bits above the field are a pure sign extension.
  assign imm_match = (&cand[31:7]) | ~(|cand[31:7]);
  assign mem_match = (&val_q[31:11]) | ~(|val_q[31:11]);

`ifdef OPERAND2_EARLY_EXIT_EN
  assign last_eval = imm_match | (r == RW'(15));
`else
  assign last_eval = (r == RW'(15));
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      r             <= '0;
      val_q         <= '0;
      mode_q        <= 1'b0;
      found_q       <= 1'b0;
      best_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      valid         <= 1'b0;
      shift_operand <= '0;
    end else begin
      state         <= state_d;
      r             <= r_d;
      val_q         <= val_d;
      mode_q        <= mode_d;
      found_q       <= found_d;
      best_q        <= best_d;
      busy          <= (state_d == S_SEARCH);
      done          <= (state_d == S_DONE);
      valid         <= valid_d;
      shift_operand <= so_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    r_d     = r;
    val_d   = val_q;
    mode_d  = mode_q;
    found_d = found_q;
    best_d  = best_q;
    valid_d = valid;
    so_d    = shift_operand;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEARCH;
          val_d   = value;
          mode_d  = ld_str;
          r_d     = '0;
          found_d = 1'b0;
          best_d  = '0;
          valid_d = 1'b0;
          so_d    = '0;
        end
      end

      S_SEARCH: begin
        if (mode_q) begin
          state_d = S_DONE;
          valid_d = mem_match;
          so_d    = mem_match ? val_q[11:0] : '0;
        end else begin
          // Remember only the first (lowest r) hit while the full scan continues.
          if (imm_match && !found_q) begin
            found_d = 1'b1;
            best_d  = {r, cand[7:0]};
          end
          if (last_eval) begin
            state_d = S_DONE;
            valid_d = found_q | imm_match;
            if (found_q)        so_d = best_q;
            else if (imm_match) so_d = {r, cand[7:0]};
            else                so_d = '0;
          end else begin
            r_d = RW'(r + RW'(1));
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_operand2_encoder.sv
// Directed self-checking bench for operand2_encoder.
// The cycle numbering follows the block's definition: the start-sampling edge closes cycle 0.
// done must be observed in the cycle numbered k+2, where k is the evaluation that settles the result.
module tb_operand2_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        ld_str;
  logic        busy;
  logic        done;
  logic        valid;
  logic [11:0] shift_operand;

  int checks = 0;
  int errors = 0;

`ifdef OPERAND2_EARLY_EXIT_EN
  localparam int C7F = 2;
  localparam int C3F = 6;
  localparam int CFC0 = 15;
  localparam int CF80 = 2;
`else
  localparam int C7F = 17;
  localparam int C3F = 17;
  localparam int CFC0 = 17;
  localparam int CF80 = 17;
`endif

  operand2_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .value         (value),
    .ld_str        (ld_str),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .shift_operand (shift_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s/%s: got %0h expected %0h", tag, what, got, exp);
    end
  endtask

  // Issues one request and follows it to done.
  // At cycle inj, a second start carrying value 1 is injected.
  task automatic run_req(input string tag, input logic [31:0] v, input logic m,
                         input logic ev, input logic [11:0] eso,
                         input int ecyc, input int inj);
    int cyc;
    bit seen;
    start  = 1'b1;
    value  = v;
    ld_str = m;
    @(posedge clk); #1;
    start  = 1'b0;
    value  = 32'hA5A5_A5A5;   // later input changes must be ignored
    ld_str = ~m;
    check(tag, "cleared_valid", 32'(valid), 32'(0));
    check(tag, "cleared_so", 32'(shift_operand), 32'(0));
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) check(tag, "busy_in_search", 32'(busy), 32'(1));
      start = (cyc == inj);
      if (cyc == inj) value = 32'h1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check(tag, "done_seen", 32'(seen), 32'(1));
    check(tag, "done_cycle", 32'(cyc), 32'(ecyc));
    check(tag, "busy_at_done", 32'(busy), 32'(0));
    check(tag, "valid", 32'(valid), 32'(ev));
    check(tag, "shift_operand", 32'(shift_operand), 32'(eso));
    @(posedge clk); #1;
    check(tag, "done_pulse_1cyc", 32'(done), 32'(0));
    check(tag, "idle_not_busy", 32'(busy), 32'(0));
    check(tag, "valid_hold", 32'(valid), 32'(ev));
    check(tag, "so_hold", 32'(shift_operand), 32'(eso));
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    value  = '0;
    ld_str = 1'b0;
    #1;
    check("reset", "busy", 32'(busy), 32'(0));
    check("reset", "done", 32'(done), 32'(0));
    check("reset", "valid", 32'(valid), 32'(0));
    check("reset", "so", 32'(shift_operand), 32'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // The first start after the reset release is taken at the first edge.
    run_req("imm_7f", 32'h0000_007F, 1'b0, 1'b1, 12'h07F, C7F, -1);
    run_req("imm_3f", 32'h3F00_0000, 1'b0, 1'b1, 12'h43F, C3F, -1);
    run_req("imm_ff80", 32'hFFFF_FF80, 1'b0, 1'b1, 12'h080, CF80, -1);
    run_req("imm_ff", 32'h0000_00FF, 1'b0, 1'b0, 12'h000, 17, -1);
    run_req("imm_fc0", 32'h0000_0FC0, 1'b0, 1'b1, 12'hD3F, CFC0, -1);
    run_req("mem_f800", 32'hFFFF_F800, 1'b1, 1'b1, 12'h800, 2, -1);
    run_req("mem_800", 32'h0000_0800, 1'b1, 1'b0, 12'h000, 2, -1);
    run_req("mem_7ff", 32'h0000_07FF, 1'b1, 1'b1, 12'h7FF, 2, -1);
    run_req("imm_ignore", 32'h3F00_0000, 1'b0, 1'b1, 12'h43F, C3F, 3);

    // No queued request may follow the ignored start.
    @(posedge clk); #1;
    check("no_queue", "busy", 32'(busy), 32'(0));

    // Asynchronous reset clears a held valid result at once.
    run_req("pre_rst", 32'h0000_007F, 1'b0, 1'b1, 12'h07F, C7F, -1);
    #2 rst = 1'b0;
    #1;
    check("rst_idle", "valid", 32'(valid), 32'(0));
    check("rst_idle", "so", 32'(shift_operand), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset asserted in cycle 3 of a search aborts it.
    start  = 1'b1;
    value  = 32'h3F00_0000;
    ld_str = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid", "busy_before", 32'(busy), 32'(1));
    #2 rst = 1'b0;
    #1;
    check("rst_mid", "busy", 32'(busy), 32'(0));
    check("rst_mid", "done", 32'(done), 32'(0));
    check("rst_mid", "valid", 32'(valid), 32'(0));
    check("rst_mid", "so", 32'(shift_operand), 32'(0));
    @(posedge clk); #1;
    check("rst_mid", "no_done", 32'(done), 32'(0));
    rst = 1'b1;
    run_req("after_rst", 32'hFFFF_FF80, 1'b0, 1'b1, 12'h080, CF80, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
